// File: rtl/hazard_stall_control.sv
// Pipeline hazard/stall controller: priority FSM (MEM_WAIT > FLUSH > LOAD_STALL > RUN) with Moore outputs.
// Optional macro STALL_PERF_CNT_EN builds a saturating count of non-RUN cycles on stall_count.
module hazard_stall_control (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic        mem_busy,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_bubble,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        pipe_hold,
    output logic [1:0]  ctrl_state,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LOAD_STALL = 2'b01,
        FLUSH      = 2'b10,
        MEM_WAIT   = 2'b11
    } state_t;

    state_t state;
    state_t next_state;

    // A held stall request alternates with RUN so a stuck request cannot deadlock the pipe.
    always_comb begin
        next_state = RUN;
        if (mem_busy)
            next_state = MEM_WAIT;
        else if (branch_taken)
            next_state = FLUSH;
        else if (stall && (state != LOAD_STALL))
            next_state = LOAD_STALL;
    end

    // Outputs are decoded from the state being entered so they register alongside it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= RUN;
            pc_write     <= 1'b1;
            if_id_write  <= 1'b1;
            id_ex_bubble <= 1'b0;
            if_id_flush  <= 1'b0;
            id_ex_flush  <= 1'b0;
            pipe_hold    <= 1'b0;
        end else begin
            state        <= next_state;
            pc_write     <= 1'b0;
            if_id_write  <= 1'b0;
            id_ex_bubble <= 1'b0;
            if_id_flush  <= 1'b0;
            id_ex_flush  <= 1'b0;
            pipe_hold    <= 1'b0;
            case (next_state)
                RUN: begin
                    pc_write    <= 1'b1;
                    if_id_write <= 1'b1;
                end
                LOAD_STALL: begin
                    id_ex_bubble <= 1'b1;
                end
                FLUSH: begin
                    pc_write    <= 1'b1;
                    if_id_write <= 1'b1;
                    if_id_flush <= 1'b1;
                    id_ex_flush <= 1'b1;
                end
                MEM_WAIT: begin
                    pipe_hold <= 1'b1;
                end
                default: begin
                    pc_write    <= 1'b1;
                    if_id_write <= 1'b1;
                end
            endcase
        end
    end

    assign ctrl_state = state;

`ifdef STALL_PERF_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clock) begin
        if (reset)
            stall_cnt_q <= 16'h0000;
        else if ((state != RUN) && (stall_cnt_q != 16'hFFFF))
            stall_cnt_q <= stall_cnt_q + 16'h0001;
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_stall_control.sv
// Self-checking bench for hazard_stall_control: directed scenarios plus random traffic against a rule-level model.
// Define STALL_PERF_CNT_EN to also exercise the saturating stall counter.
module tb_hazard_stall_control;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic        mem_busy = 1'b0;
    logic        pc_write;
    logic        if_id_write;
    logic        id_ex_bubble;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        pipe_hold;
    logic [1:0]  ctrl_state;
    logic [15:0] stall_count;

    int checks = 0;
    int failures = 0;

`ifdef STALL_PERF_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    // Model: 0=RUN 1=LOAD_STALL 2=FLUSH 3=MEM_WAIT, plus a count of non-RUN cycles.
    int model_state = 0;
    int model_cnt = 0;

    hazard_stall_control dut (
        .clock        (clock),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .mem_busy     (mem_busy),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .id_ex_bubble (id_ex_bubble),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .pipe_hold    (pipe_hold),
        .ctrl_state   (ctrl_state),
        .stall_count  (stall_count)
    );

    always #5 clock = ~clock;

    function automatic int rule_next(int cur, bit s, bit b, bit m);
        if (m) return 3;
        if (b) return 2;
        if (s && cur != 1) return 1;
        return 0;
    endfunction

    // {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, pipe_hold}
    function automatic logic [5:0] rule_outputs(int st);
        logic [5:0] table_v [4];
        table_v[0] = 6'b110000;
        table_v[1] = 6'b001000;
        table_v[2] = 6'b110110;
        table_v[3] = 6'b000001;
        return table_v[st];
    endfunction

    task automatic checkOutput(input string tag);
        logic [5:0] obs_ctl;
        logic [5:0] exp_ctl;
        logic [1:0] exp_state;
        logic [15:0] exp_cnt;
        obs_ctl   = {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, pipe_hold};
        exp_ctl   = rule_outputs(model_state);
        exp_state = 2'(model_state);
        exp_cnt   = 16'(model_cnt);
        checks++;
        assert (ctrl_state === exp_state) else begin
            failures++;
            $error("[TB] FAIL %s ctrl_state observed=%0d expected=%0d", tag, ctrl_state, exp_state);
        end
        checks++;
        assert (obs_ctl === exp_ctl) else begin
            failures++;
            $error("[TB] FAIL %s controls observed=%b expected=%b", tag, obs_ctl, exp_ctl);
        end
        checks++;
        assert (stall_count === exp_cnt) else begin
            failures++;
            $error("[TB] FAIL %s stall_count observed=%0d expected=%0d", tag, stall_count, exp_cnt);
        end
        checks++;
        assert (!(pc_write && pipe_hold) && !(if_id_flush && !if_id_write)) else begin
            failures++;
            $error("[TB] FAIL %s invariant observed=%b expected=no-conflict", tag, obs_ctl);
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, then check outputs 1 time unit later.
    task automatic applyStimulus(input bit r, input bit s, input bit b, input bit m, input string tag);
        reset        = r;
        stall        = s;
        branch_taken = b;
        mem_busy     = m;
        @(posedge clock);
        if (r) begin
            model_state = 0;
            model_cnt   = 0;
        end else begin
            if (CntEn && model_state != 0 && model_cnt < 65535) model_cnt++;
            model_state = rule_next(model_state, s, b, m);
        end
        #1;
        checkOutput(tag);
    endtask

    initial begin
        // Reset held two cycles with stall and mem_busy high.
        applyStimulus(1, 1, 0, 1, "reset1");
        applyStimulus(1, 1, 0, 1, "reset2");
        checks++;
        assert (ctrl_state === 2'b00 && pc_write === 1'b1 && stall_count === 16'h0000) else begin
            failures++;
            $error("[TB] FAIL reset_const observed=%0d/%b/%0d expected=0/1/0", ctrl_state, pc_write, stall_count);
        end

        // Single-cycle stall.
        applyStimulus(0, 1, 0, 0, "stall_one");
        checks++;
        assert (ctrl_state === 2'b01 && id_ex_bubble === 1'b1 && pc_write === 1'b0) else begin
            failures++;
            $error("[TB] FAIL stall_one_const observed=%0d/%b/%b expected=1/1/0", ctrl_state, id_ex_bubble, pc_write);
        end
        applyStimulus(0, 0, 0, 0, "stall_one_exit");

        // Held stall alternates LOAD_STALL / RUN.
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, "stall_held");
        applyStimulus(0, 0, 0, 0, "stall_held_exit");

        // Stall with branch picks FLUSH, and the stall is dropped.
        applyStimulus(0, 1, 1, 0, "stall_branch");
        checks++;
        assert (ctrl_state === 2'b10 && if_id_flush === 1'b1 && id_ex_flush === 1'b1) else begin
            failures++;
            $error("[TB] FAIL stall_branch_const observed=%0d/%b/%b expected=2/1/1", ctrl_state, if_id_flush, id_ex_flush);
        end
        applyStimulus(0, 0, 0, 0, "flush_exit");

        // Five cycles of mem_busy with a branch in the third.
        applyStimulus(1, 0, 0, 0, "reset_mem");
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, (i == 2), 1, "mem_wait");
        applyStimulus(0, 0, 0, 0, "mem_exit");
        checks++;
        assert (stall_count === (CntEn ? 16'd5 : 16'd0)) else begin
            failures++;
            $error("[TB] FAIL mem_count observed=%0d expected=%0d", stall_count, (CntEn ? 5 : 0));
        end

        // Reset in the middle of MEM_WAIT and FLUSH.
        applyStimulus(0, 0, 0, 1, "pre_reset_mw");
        applyStimulus(1, 0, 0, 1, "reset_mid_mw");
        applyStimulus(0, 0, 1, 0, "pre_reset_fl");
        applyStimulus(1, 1, 1, 0, "reset_mid_fl");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            bit r, s, b, m;
            r = ($urandom_range(0, 49) == 0);
            s = ($urandom_range(0, 2) == 0);
            b = ($urandom_range(0, 4) == 0);
            m = ($urandom_range(0, 5) == 0);
            applyStimulus(r, s, b, m, "random");
        end

`ifdef STALL_PERF_CNT_EN
        // Long memory wait drives the counter into saturation.
        applyStimulus(1, 0, 0, 0, "reset_sat");
        for (int i = 0; i < 70000; i++) applyStimulus(0, 0, 0, 1, "sat_run");
        checks++;
        assert (stall_count === 16'hFFFF) else begin
            failures++;
            $error("[TB] FAIL saturate observed=%0h expected=ffff", stall_count);
        end
        applyStimulus(1, 0, 0, 1, "sat_clear");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
